gf_serial_subtractor: RTL and testbench

GF_SERIAL_SUBTRACTOR -- requirements
Module: gf_serial_subtractor

---
 rtl/gf_ops_pkg.sv | 14 +
 rtl/gf_sub_digit.sv | 30 +++
 rtl/gf_serial_subtractor.sv | 141 ++++++++++++++
 tb/tb_gf_serial_subtractor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/gf_ops_pkg.sv
// Shared definitions for the serial GF/integer subtractor: FSM states and
// the encoding of the gf_option mode select.
package gf_ops_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } gf_state_e;

  localparam logic GF_MODE  = 1'b1;
  localparam logic INT_MODE = 1'b0;

endpackage : gf_ops_pkg

// File: rtl/gf_sub_digit.sv
// One-digit subtractor: integer mode subtracts with borrow-in and reports
// borrow-out; GF(2) mode is a plain XOR with no borrow at all.
module gf_sub_digit
  import gf_ops_pkg::*;
#(
  parameter int DIGIT_WIDTH = 8
) (
  input  logic [DIGIT_WIDTH-1:0] a,
  input  logic [DIGIT_WIDTH-1:0] b,
  input  logic                   bi,
  input  logic                   gf_option,
  output logic [DIGIT_WIDTH-1:0] diff,
  output logic                   bo
);

  logic [DIGIT_WIDTH:0] int_res;

  // Extend by one bit so the borrow out lands in the MSB of the result.
  always_comb begin
    int_res = {1'b0, a} - {1'b0, b} - {{DIGIT_WIDTH{1'b0}}, bi};
    if (gf_option == GF_MODE) begin
      diff = a ^ b;
      bo   = 1'b0;
    end else begin
      diff = int_res[DIGIT_WIDTH-1:0];
      bo   = int_res[DIGIT_WIDTH];
    end
  end

endmodule : gf_sub_digit

// File: rtl/gf_serial_subtractor.sv
// Digit-serial subtractor with valid/ready handshakes on both sides.
// Operands are latched on accept, one digit is processed per cycle LSB first,
// and the result is held in DONE until the consumer takes it.
module gf_serial_subtractor
  import gf_ops_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DIGIT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  gf_option,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] diff,
  output logic                  bo
);

  localparam int N_DIGITS = DATA_WIDTH / DIGIT_WIDTH;
  localparam int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  gf_state_e             state_q,     state_d;
  logic                  in_ready_q,  in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] diff_q,      diff_d;
  logic                  bo_q,        bo_d;
  logic                  borrow_q,    borrow_d;
  logic [IDX_W-1:0]      idx_q,       idx_d;

  // Operand holding registers; only written on accept, so no reset needed.
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic                  gf_q;
  logic                  load;

  logic [DIGIT_WIDTH-1:0] dig_a, dig_b, dig_diff;
  logic                   dig_bo;

  assign dig_a = a_q[idx_q*DIGIT_WIDTH +: DIGIT_WIDTH];
  assign dig_b = b_q[idx_q*DIGIT_WIDTH +: DIGIT_WIDTH];

  gf_sub_digit #(
    .DIGIT_WIDTH (DIGIT_WIDTH)
  ) u_digit (
    .a         (dig_a),
    .b         (dig_b),
    .bi        (borrow_q),
    .gf_option (gf_q),
    .diff      (dig_diff),
    .bo        (dig_bo)
  );

  // Next-state and datapath update; handshake inputs only reach outputs
  // through the registered state below.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    bo_d        = bo_q;
    borrow_d    = borrow_q;
    idx_d       = idx_q;
    load        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          load       = 1'b1;
          borrow_d   = 1'b0;
          bo_d       = 1'b0;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        diff_d[idx_q*DIGIT_WIDTH +: DIGIT_WIDTH] = dig_diff;
        borrow_d = dig_bo;
        if (idx_q == LAST_IDX) begin
          bo_d        = dig_bo;
          idx_d       = '0;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // Control and result registers with asynchronous abort to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bo_q        <= 1'b0;
      borrow_q    <= 1'b0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      bo_q        <= bo_d;
      borrow_q    <= borrow_d;
      idx_q       <= idx_d;
    end
  end

  // Operand capture on accept; held untouched through BUSY and DONE.
  always_ff @(posedge clk) begin
    if (load) begin
      a_q  <= a;
      b_q  <= b;
      gf_q <= gf_option;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bo        = bo_q;

endmodule : gf_serial_subtractor

// File: tb/tb_gf_serial_subtractor.sv
// Bench for gf_serial_subtractor (32-bit operands, 8-bit digits).
module tb_gf_serial_subtractor;

  localparam int DW  = 32;
  localparam int GW  = 8;
  localparam int LAT = DW / GW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          gf_option = 1'b0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] diff;
  logic          bo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          gf;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp_diff;
    logic          exp_bo;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    logic          bo;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[8];

  gf_serial_subtractor #(
    .DATA_WIDTH  (DW),
    .DIGIT_WIDTH (GW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .gf_option (gf_option),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bo        (bo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  // Pop the scoreboard and compare against the result currently presented.
  task automatic sb_compare(input string name);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s_sb act=result exp=no_pending", name);
    end else begin
      e = sb_q.pop_front();
      checks--;
      chk({name, "_diff"}, 64'(diff), 64'(e.d));
      chk({name, "_bo"}, 64'(bo), 64'(e.bo));
    end
  endtask

  // Called #1 after a posedge; performs a full transaction.
  task automatic do_op(input string name, input logic g, input logic [DW-1:0] x,
                       input logic [DW-1:0] y, input logic [DW-1:0] ed, input logic eb,
                       input int hold, input logic early);
    int lat;
    logic [DW-1:0] d0;
    logic b0;
    exp_t e;
    in_valid  = 1'b1;
    a         = x;
    b         = y;
    gf_option = g;
    out_ready = early;
    chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    e.d = ed; e.bo = eb;
    sb_q.push_back(e);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      a = $urandom; b = $urandom; gf_option = ~gf_option; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(LAT));
    if (early) begin
      sb_compare(name);
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({name, "_oneshot_valid"}, 64'(out_valid), 64'd0);
      chk({name, "_idle_ready"}, 64'(in_ready), 64'd1);
    end else begin
      d0 = diff; b0 = bo;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk({name, "_hold_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        chk({name, "_hold_diff"}, 64'(diff), 64'(d0));
        chk({name, "_hold_bo"}, 64'(bo), 64'(b0));
      end
      out_ready = 1'b1;
      sb_compare(name);
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({name, "_post_valid"}, 64'(out_valid), 64'd0);
      chk({name, "_post_in_ready"}, 64'(in_ready), 64'd1);
    end
  endtask

  initial begin
    logic [DW-1:0] rx, ry;
    logic rg;
    vecs[0] = '{1'b0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1};
    vecs[2] = '{1'b0, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0};
    vecs[3] = '{1'b1, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'hAAAA_AAAA, 1'b0};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[5] = '{1'b0, 32'h1234_5678, 32'h8765_4321, 32'h8ACF_1357, 1'b1};
    vecs[6] = '{1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 32'hEDCB_A987, 1'b0};
    vecs[7] = '{1'b0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0};

    // Reset values while rst_n is held low.
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_diff", 64'(diff), 64'd0);
    chk("rst_bo", 64'(bo), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table vectors; first one accepted on the first edge after reset release.
    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].gf, vecs[i].a, vecs[i].b,
            vecs[i].exp_diff, vecs[i].exp_bo, (i % 2 == 0) ? 1 : 0, 1'b0);

    // Consumer ready before DONE: result presented for exactly one cycle.
    do_op("early", 1'b0, 32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 0, 1'b1);

    // Long stall in DONE.
    do_op("stall", 1'b0, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1, 10, 1'b0);

    // Random operands against a behavioural reference.
    for (int i = 0; i < 6; i++) begin
      rx = $urandom; ry = $urandom; rg = 1'($urandom_range(0, 1));
      do_op($sformatf("rnd%0d", i), rg, rx, ry, rg ? (rx ^ ry) : (rx - ry),
            rg ? 1'b0 : (rx < ry), i % 3, 1'(i % 2));
    end

    // Abort in the second BUSY cycle.
    in_valid = 1'b1; a = 32'h0000_0009; b = 32'h0000_0004; gf_option = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_diff", 64'(diff), 64'd0);
    chk("abort_bo", 64'(bo), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      chk("abort_no_result", 64'(seen), 64'd0);
    end
    chk("abort_sb_empty", 64'(sb_q.size()), 64'd0);
    do_op("post_abort", 1'b0, 32'h0000_0009, 32'h0000_0004, 32'h0000_0005, 1'b0, 1, 1'b0);
    chk("final_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_gf_serial_subtractor
